// File: rtl/pe_drv_pkg.sv
// Shared types and default sizing for the 1-D convolution PE driver.
// Holds the driver/sender FSM enums, the debug bundle and the output-count derivation.
package pe_drv_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int PSUM_W_DEF  = 16;
    localparam int DEPTH_I_DEF = 5;
    localparam int ADDR_I_DEF  = 3;
    localparam int DEPTH_F_DEF = 3;
    localparam int ADDR_F_DEF  = 2;
    localparam int TIMEOUT_DEF = 1024;

    // Six sender channels contribute {req, synced ack}; two receivers {synced req, ack}.
    localparam int HS_PHASE_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_HOST,
        ST_SEND_F,
        ST_SEND_I,
        ST_SEND_START,
        ST_SEND_PSUM,
        ST_RECV_PSUM,
        ST_RECV_DONE,
        ST_ERR
    } drv_state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_DATA,
        HS_REQ,
        HS_REL
    } hs_state_e;

    typedef struct packed {
        drv_state_e              state;
        logic                    done_flag;
        logic [HS_PHASE_W-1:0]   hs_phase;
    } drv_dbg_t;

    function automatic int n_out(input int depth_i, input int depth_f);
        return depth_i - depth_f + 1;
    endfunction

    localparam int N_OUT_DEF = n_out(DEPTH_I_DEF, DEPTH_F_DEF);

endpackage

// File: rtl/pe_conv1d_driver_hs4_sender.sv
// Four-phase bundled-data sender: latch data, raise req a cycle later, wait for the
// synchronized ack to rise, drop req, then wait for the synchronized ack to fall.
module hs4_sender
    import pe_drv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         start_i,
    input  logic [W-1:0] data_i,
    output logic         req_o,
    input  logic         ack_i,
    output logic [W-1:0] data_o,
    output logic         idle_o,
    output logic         ack_sync_o
);

    hs_state_e    state_q;
    logic         req_q;
    logic [W-1:0] data_q;
    logic         ack_meta_q;
    logic         ack_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= ack_i;
            ack_sync_q <= ack_meta_q;
        end
    end

    // clr_i abandons a transfer in progress so req falls regardless of the ack level.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            state_q <= HS_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                HS_IDLE: begin
                    if (start_i) begin
                        data_q  <= data_i;
                        state_q <= HS_DATA;
                    end
                end
                HS_DATA: begin
                    req_q   <= 1'b1;
                    state_q <= HS_REQ;
                end
                HS_REQ: begin
                    if (ack_sync_q) begin
                        req_q   <= 1'b0;
                        state_q <= HS_REL;
                    end
                end
                HS_REL: begin
                    if (!ack_sync_q) begin
                        state_q <= HS_IDLE;
                    end
                end
                default: state_q <= HS_IDLE;
            endcase
        end
    end

    assign req_o      = req_q;
    assign data_o     = data_q;
    assign idle_o     = (state_q == HS_IDLE);
    assign ack_sync_o = ack_sync_q;

endmodule

// File: rtl/pe_conv1d_driver.sv
// Host-to-PE driver for a 1-D convolution PE: buffers filter, ifmap and psum seeds from
// the host, streams them over 4-phase channels and returns psums. PE_DRV_TIMEOUT_EN adds a watchdog.
module pe_conv1d_driver
    import pe_drv_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int PSUM_W  = PSUM_W_DEF,
    parameter int DEPTH_I = DEPTH_I_DEF,
    parameter int ADDR_I  = ADDR_I_DEF,
    parameter int DEPTH_F = DEPTH_F_DEF,
    parameter int ADDR_F  = ADDR_F_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PSUM_W-1:0] in_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PSUM_W-1:0] res_data,
    output logic              filter_in_req,
    input  logic              filter_in_ack,
    output logic [WIDTH-1:0]  filter_in_data,
    output logic              filter_addr_req,
    input  logic              filter_addr_ack,
    output logic [ADDR_F-1:0] filter_addr_data,
    output logic              ifmap_in_req,
    input  logic              ifmap_in_ack,
    output logic [WIDTH-1:0]  ifmap_in_data,
    output logic              ifmap_addr_req,
    input  logic              ifmap_addr_ack,
    output logic [ADDR_I-1:0] ifmap_addr_data,
    output logic              psum_in_req,
    input  logic              psum_in_ack,
    output logic [PSUM_W-1:0] psum_in_data,
    output logic              start_req,
    input  logic              start_ack,
    output logic              start_data,
    input  logic              psum_out_req,
    output logic              psum_out_ack,
    input  logic [PSUM_W-1:0] psum_out_data,
    input  logic              done_req,
    output logic              done_ack,
    input  logic              done_data,
    output logic              busy,
    output logic              err,
    output drv_dbg_t          dbg
);

    localparam int N_OUT    = n_out(DEPTH_I, DEPTH_F);
    localparam int LD_TOTAL = DEPTH_F + DEPTH_I + N_OUT;
    localparam int LD_W     = $clog2(LD_TOTAL);
    localparam int OUT_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    drv_state_e        state_q;
    logic [LD_W-1:0]   ld_q;
    logic [ADDR_I-1:0] k_q;
    logic [OUT_W-1:0]  o_q;
    logic              launched_q;
    logic              res_valid_q;
    logic [PSUM_W-1:0] res_data_q;
    logic              po_meta_q, po_sync_q, po_ack_q;
    logic              dn_meta_q, dn_sync_q, dn_ack_q;
    logic              done_flag_q;
    logic [PSUM_W-1:0] rf_q [LD_TOTAL];

    logic [LD_W-1:0]   rd_idx;
    logic [PSUM_W-1:0] rd_word;
    logic              res_free;
    logic              wd_hit;
    logic              snd_clr;
    logic [HS_PHASE_W-1:0] hs_phase;

    logic fi_start, ii_start, st_start, ps_start;
    logic fi_idle, fa_idle, ii_idle, ia_idle, ps_idle, st_idle;
    logic fi_ack_s, fa_ack_s, ii_ack_s, ia_ack_s, ps_ack_s, st_ack_s;

    // Register file layout: filter words, then ifmap words, then psum seeds.
    always_comb begin
        rd_idx = LD_W'(k_q);
        case (state_q)
            ST_SEND_I:    rd_idx = LD_W'(DEPTH_F) + LD_W'(k_q);
            ST_SEND_PSUM: rd_idx = LD_W'(DEPTH_F + DEPTH_I) + LD_W'(o_q);
            default:      ;
        endcase
    end

    assign rd_word  = rf_q[rd_idx];
    assign res_free = !res_valid_q || res_ready;
    assign snd_clr  = (state_q == ST_ERR) || wd_hit;

    assign fi_start = (state_q == ST_SEND_F)     && !launched_q;
    assign ii_start = (state_q == ST_SEND_I)     && !launched_q;
    assign st_start = (state_q == ST_SEND_START) && !launched_q;
    assign ps_start = (state_q == ST_SEND_PSUM)  && !launched_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            po_meta_q <= 1'b0;
            po_sync_q <= 1'b0;
            dn_meta_q <= 1'b0;
            dn_sync_q <= 1'b0;
        end else begin
            po_meta_q <= psum_out_req;
            po_sync_q <= po_meta_q;
            dn_meta_q <= done_req;
            dn_sync_q <= dn_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ld_q        <= '0;
            k_q         <= '0;
            o_q         <= '0;
            launched_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            po_ack_q    <= 1'b0;
            dn_ack_q    <= 1'b0;
            done_flag_q <= 1'b0;
        end else begin
            if (res_valid_q && res_ready) begin
                res_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    ld_q <= '0;
                    if (in_valid) begin
                        done_flag_q <= 1'b0;
                        state_q     <= ST_LOAD_HOST;
                    end
                end
                ST_LOAD_HOST: begin
                    if (in_valid) begin
                        rf_q[ld_q] <= in_data;
                        if (ld_q == LD_W'(LD_TOTAL - 1)) begin
                            ld_q    <= '0;
                            k_q     <= '0;
                            state_q <= ST_SEND_F;
                        end else begin
                            ld_q <= ld_q + 1'b1;
                        end
                    end
                end
                ST_SEND_F: begin
                    if (!launched_q) begin
                        launched_q <= 1'b1;
                    end else if (fi_idle && fa_idle) begin
                        launched_q <= 1'b0;
                        if (k_q == ADDR_I'(DEPTH_F - 1)) begin
                            k_q     <= '0;
                            state_q <= ST_SEND_I;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                ST_SEND_I: begin
                    if (!launched_q) begin
                        launched_q <= 1'b1;
                    end else if (ii_idle && ia_idle) begin
                        launched_q <= 1'b0;
                        if (k_q == ADDR_I'(DEPTH_I - 1)) begin
                            k_q     <= '0;
                            o_q     <= '0;
                            state_q <= ST_SEND_START;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                ST_SEND_START: begin
                    if (!launched_q) begin
                        launched_q <= 1'b1;
                    end else if (st_idle) begin
                        launched_q <= 1'b0;
                        state_q    <= ST_SEND_PSUM;
                    end
                end
                ST_SEND_PSUM: begin
                    if (!launched_q) begin
                        launched_q <= 1'b1;
                    end else if (ps_idle) begin
                        launched_q <= 1'b0;
                        state_q    <= ST_RECV_PSUM;
                    end
                end
                ST_RECV_PSUM: begin
                    // The ack is withheld while an unread result still occupies the output register.
                    if (!po_ack_q) begin
                        if (po_sync_q && res_free) begin
                            res_data_q  <= psum_out_data;
                            res_valid_q <= 1'b1;
                            po_ack_q    <= 1'b1;
                        end
                    end else if (!po_sync_q) begin
                        po_ack_q <= 1'b0;
                        if (o_q == OUT_W'(N_OUT - 1)) begin
                            state_q <= ST_RECV_DONE;
                        end else begin
                            o_q     <= o_q + 1'b1;
                            state_q <= ST_SEND_PSUM;
                        end
                    end
                end
                ST_RECV_DONE: begin
                    if (!dn_ack_q) begin
                        if (dn_sync_q) begin
                            done_flag_q <= done_data;
                            dn_ack_q    <= 1'b1;
                        end
                    end else if (!dn_sync_q) begin
                        dn_ack_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    po_ack_q <= 1'b0;
                    dn_ack_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (wd_hit) begin
                state_q    <= ST_ERR;
                launched_q <= 1'b0;
                po_ack_q   <= 1'b0;
                dn_ack_q   <= 1'b0;
            end
        end
    end

    assign hs_phase = {filter_in_req, fi_ack_s, filter_addr_req, fa_ack_s,
                       ifmap_in_req, ii_ack_s, ifmap_addr_req, ia_ack_s,
                       psum_in_req, ps_ack_s, start_req, st_ack_s,
                       po_sync_q, po_ack_q, dn_sync_q, dn_ack_q};

`ifdef PE_DRV_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]       wd_q;
    logic [HS_PHASE_W-1:0] phase_q;
    logic                  err_q;
    logic                  wd_run;

    // Host back-pressure on the result register is not a PE stall, so it does not count.
    assign wd_run = (state_q inside {ST_SEND_F, ST_SEND_I, ST_SEND_START, ST_SEND_PSUM,
                                     ST_RECV_PSUM, ST_RECV_DONE})
                    && !(res_valid_q && !res_ready);
    assign wd_hit = wd_run && (wd_q == TO_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        phase_q <= hs_phase;
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (!wd_run || (hs_phase != phase_q)) begin
                wd_q <= '0;
            end else if (!wd_hit) begin
                wd_q <= wd_q + 1'b1;
            end
            if (wd_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

    hs4_sender #(.W(WIDTH)) u_filter_in (
        .clk(clk), .rst(rst), .clr_i(snd_clr), .start_i(fi_start),
        .data_i(rd_word[WIDTH-1:0]), .req_o(filter_in_req), .ack_i(filter_in_ack),
        .data_o(filter_in_data), .idle_o(fi_idle), .ack_sync_o(fi_ack_s)
    );

    hs4_sender #(.W(ADDR_F)) u_filter_addr (
        .clk(clk), .rst(rst), .clr_i(snd_clr), .start_i(fi_start),
        .data_i(k_q[ADDR_F-1:0]), .req_o(filter_addr_req), .ack_i(filter_addr_ack),
        .data_o(filter_addr_data), .idle_o(fa_idle), .ack_sync_o(fa_ack_s)
    );

    hs4_sender #(.W(WIDTH)) u_ifmap_in (
        .clk(clk), .rst(rst), .clr_i(snd_clr), .start_i(ii_start),
        .data_i(rd_word[WIDTH-1:0]), .req_o(ifmap_in_req), .ack_i(ifmap_in_ack),
        .data_o(ifmap_in_data), .idle_o(ii_idle), .ack_sync_o(ii_ack_s)
    );

    hs4_sender #(.W(ADDR_I)) u_ifmap_addr (
        .clk(clk), .rst(rst), .clr_i(snd_clr), .start_i(ii_start),
        .data_i(k_q), .req_o(ifmap_addr_req), .ack_i(ifmap_addr_ack),
        .data_o(ifmap_addr_data), .idle_o(ia_idle), .ack_sync_o(ia_ack_s)
    );

    hs4_sender #(.W(PSUM_W)) u_psum_in (
        .clk(clk), .rst(rst), .clr_i(snd_clr), .start_i(ps_start),
        .data_i(rd_word), .req_o(psum_in_req), .ack_i(psum_in_ack),
        .data_o(psum_in_data), .idle_o(ps_idle), .ack_sync_o(ps_ack_s)
    );

    hs4_sender #(.W(1)) u_start (
        .clk(clk), .rst(rst), .clr_i(snd_clr), .start_i(st_start),
        .data_i(1'b1), .req_o(start_req), .ack_i(start_ack),
        .data_o(start_data), .idle_o(st_idle), .ack_sync_o(st_ack_s)
    );

    assign in_ready       = (state_q == ST_LOAD_HOST);
    assign busy           = (state_q != ST_IDLE);
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign psum_out_ack   = po_ack_q;
    assign done_ack       = dn_ack_q;
    assign dbg.state      = state_q;
    assign dbg.done_flag  = done_flag_q;
    assign dbg.hs_phase   = hs_phase;

endmodule

// File: doc/pe_conv1d_driver.md
PE_CONV1D_DRIVER -- requirements
Module: pe_conv1d_driver

Interface
REQ-001 Parameters SHALL be: WIDTH=8, ifmap/filter word width; PSUM_W=16, partial-sum width; DEPTH_I=5, ifmap length; ADDR_I=3, ifmap address width; DEPTH_F=3, filter length; ADDR_F=2, filter address width; TIMEOUT=1024, watchdog limit in cycles.
REQ-002 Ports: clk in 1, sole clock; rst in 1, synchronous active-high reset.
REQ-003 Host input: in_valid in 1; in_ready out 1; in_data in PSUM_W, low WIDTH bits used for filter/ifmap words.
REQ-004 Host output: res_valid out 1; res_ready in 1; res_data out PSUM_W.
REQ-005 PE output channels, each 4-phase bundled-data (req out 1, ack in 1, data out): filter_in (WIDTH), filter_addr (ADDR_F), ifmap_in (WIDTH), ifmap_addr (ADDR_I), psum_in (PSUM_W), start (1).
REQ-006 PE input channels, each 4-phase bundled-data (req in 1, ack out 1, data in): psum_out (PSUM_W), done (1).
REQ-007 Status: busy out 1, high in any state other than IDLE; err out 1, sticky watchdog flag.

Function
REQ-008 Host SHALL supply, in order, DEPTH_F filter words, DEPTH_I ifmap words, then N_OUT=DEPTH_I-DEPTH_F+1 psum seeds, all into internal register files.
REQ-009 in_ready SHALL be high only in states LOAD_HOST; a word transfers on in_valid&&in_ready at the clock edge.
REQ-010 FSM states SHALL be: IDLE, LOAD_HOST, SEND_F, SEND_I, SEND_START, SEND_PSUM, RECV_PSUM, RECV_DONE, ERR.
REQ-011 Transitions: IDLE->LOAD_HOST on in_valid; LOAD_HOST->SEND_F after the last seed; SEND_F->SEND_I after DEPTH_F pairs; SEND_I->SEND_START after DEPTH_I pairs; SEND_START->SEND_PSUM; SEND_PSUM->RECV_PSUM; RECV_PSUM->SEND_PSUM while outputs remain, else ->RECV_DONE; RECV_DONE->IDLE.
REQ-012 Sender handshake: drive data, then raise req on the next cycle; hold data until synchronized ack is high; drop req; complete when synchronized ack is low.
REQ-013 In SEND_F/SEND_I, address k and word k SHALL be sent concurrently on the addr and data channels; index advances only when both handshakes complete; k runs 0..DEPTH-1 and does not wrap.
REQ-014 Every PE-side ack/req input SHALL pass through a 2-flop synchronizer; receive data SHALL be sampled on the cycle synchronized req is first seen high.
REQ-015 Receiver handshake: on synchronized req high, capture data and raise ack; drop ack once synchronized req is low.
REQ-016 RECV_PSUM SHALL NOT raise ack while res_valid is high and res_ready is low; a one-entry result register holds the captured psum.
REQ-017 res_valid SHALL stay high with res_data stable until res_ready; results SHALL appear in output-index order 0..N_OUT-1.
REQ-018 A done token arriving before RECV_DONE SHALL remain unacknowledged until RECV_DONE.
REQ-019 in_valid outside LOAD_HOST and IDLE SHALL be ignored, with in_ready held low.

Reset
REQ-020 On rst, all of the following SHALL be 0 on the next edge: FSM=IDLE, every req, every ack, in_ready, res_valid, busy, err, and all indices.
REQ-021 Reset mid-operation SHALL abandon the job; register-file contents are don't-care; the host SHALL reload the full sequence.

Configuration
REQ-022 With PE_DRV_TIMEOUT_EN defined, a counter SHALL clear on every handshake-phase change; reaching TIMEOUT SHALL move the FSM to ERR, drop all reqs and acks, and set err; only rst leaves ERR.
REQ-023 Without PE_DRV_TIMEOUT_EN, handshakes SHALL wait indefinitely, err SHALL be tied 0, and ERR SHALL be unreachable.

Structure
REQ-024 A shared package pe_drv_pkg SHALL hold the FSM state enum, N_OUT derivation, and default widths.
REQ-025 One sub-module, hs4_sender (parameterised data width; 4-phase sender with synchronizer), SHALL be instantiated once per output channel.

Verification
REQ-026 Behavioural PE model: filter {1,2,3}, ifmap {1,2,3,4,5}, seeds {0,0,0} -> res_data 14, 20, 26, then IDLE.
REQ-027 Same data, seeds {10,0,5} -> res_data 24, 20, 31.
REQ-028 res_ready held low for 50 cycles after the first result -> psum_out ack stays low, no result is lost, and order is preserved.
REQ-029 rst asserted during SEND_I at index 2 -> all reqs are 0 next cycle; a subsequent full job produces correct results.
REQ-030 With PE_DRV_TIMEOUT_EN and the model never acking filter_addr -> err=1 after TIMEOUT cycles and the FSM is in ERR; without the macro -> busy stays 1 and err stays 0.
REQ-031 PE model delays the done token by 200 cycles -> busy stays high until done is acknowledged, then the FSM returns to IDLE.
